// File: rtl/vernam_key_mailbox.sv
// Key-stream mailbox: producer pushes key bytes into a FIFO, consumer XORs plaintext against the head.
// Optional macro KEY_MAILBOX_LEVEL_PORT_EN exposes the FIFO level at LEVEL_PORT.
module vernam_key_mailbox #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned THRESH      = 4,
    parameter logic [7:0]  KEY_PORT    = 8'h01,
    parameter logic [7:0]  DATA_PORT   = 8'h08,
    parameter logic [7:0]  STATUS_PORT = 8'h80,
    parameter logic [7:0]  LEVEL_PORT  = 8'h40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        prod_port_id,
    input  logic [DATA_W-1:0] prod_out_port,
    input  logic              prod_write_strobe,
    input  logic [7:0]        cons_port_id,
    input  logic [DATA_W-1:0] cons_out_port,
    input  logic              cons_write_strobe,
    input  logic              cons_read_strobe,
    output logic [DATA_W-1:0] cons_in_port,
    output logic              cons_interrupt,
    input  logic              cons_interrupt_ack
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
    localparam logic [PW-1:0] THRESH_L = PW'(THRESH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]     level, level_next;
    logic [DATA_W-1:0] result_q, result_d;
    logic              res_valid_q, res_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
    logic              irq_q, irq_d;

    logic empty, full;
    logic push_req, pop_req, rd_req, stat_wr;
    logic push_ok, pop_ok;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == DEPTH_L);

    assign push_req = prod_write_strobe && (prod_port_id == KEY_PORT);
    assign pop_req  = cons_write_strobe && (cons_port_id == DATA_PORT);
    assign rd_req   = cons_read_strobe && (cons_port_id == DATA_PORT);
    assign stat_wr  = cons_write_strobe && (cons_port_id == STATUS_PORT);

    // A pop frees the head slot this cycle, so a push into a full FIFO may proceed alongside it.
    assign pop_ok  = pop_req && !empty && !reset;
    assign push_ok = push_req && (!full || pop_ok) && !reset;

    assign level_next = level + PW'(push_ok) - PW'(pop_ok);

    always_comb begin
        result_d    = result_q;
        res_valid_d = res_valid_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        irq_d       = irq_q;

        if (pop_ok) begin
            result_d    = cons_out_port ^ mem_q[rd_ptr_q[AW-1:0]];
            res_valid_d = 1'b1;
        end else if (rd_req) begin
            res_valid_d = 1'b0;
        end

        // Clears first so that same-cycle set events override them.
        if (stat_wr && cons_out_port[3]) overflow_d  = 1'b0;
        if (stat_wr && cons_out_port[4]) underflow_d = 1'b0;
        if (push_req && !push_ok)        overflow_d  = 1'b1;
        if (pop_req && empty)            underflow_d = 1'b1;

        if (cons_interrupt_ack) begin
            irq_d = 1'b0;
        end else if ((level < THRESH_L) && (level_next >= THRESH_L)) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
            result_q    <= result_d;
            res_valid_q <= res_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            irq_q       <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= prod_out_port;
    end

    assign cons_interrupt = irq_q;

    // Read mux depends only on the consumer port_id and registered state.
    always_comb begin
        cons_in_port = '0;
        case (cons_port_id)
            DATA_PORT:   cons_in_port = result_q;
            STATUS_PORT: cons_in_port[4:0] = {underflow_q, overflow_q, full, empty, res_valid_q};
`ifdef KEY_MAILBOX_LEVEL_PORT_EN
            LEVEL_PORT:  cons_in_port = DATA_W'(level);
`endif
            default:     cons_in_port = '0;
        endcase
    end

endmodule

// File: tb/tb_vernam_key_mailbox.sv
// Directed bench for vernam_key_mailbox: vector table plus hand sequences for FIFO fill/drain,
// overflow/underflow, simultaneous push/pop when full, interrupt hysteresis and reset.
module tb_vernam_key_mailbox;

    localparam logic [7:0] K = 8'h01;
    localparam logic [7:0] D = 8'h08;
    localparam logic [7:0] S = 8'h80;
    localparam logic [7:0] L = 8'h40;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] prod_port_id, prod_out_port;
    logic       prod_write_strobe;
    logic [7:0] cons_port_id, cons_out_port;
    logic       cons_write_strobe, cons_read_strobe;
    logic [7:0] cons_in_port;
    logic       cons_interrupt, cons_interrupt_ack;

    int n_checks = 0;
    int n_fail   = 0;

    vernam_key_mailbox dut (
        .clk               (clk),
        .reset             (reset),
        .prod_port_id      (prod_port_id),
        .prod_out_port     (prod_out_port),
        .prod_write_strobe (prod_write_strobe),
        .cons_port_id      (cons_port_id),
        .cons_out_port     (cons_out_port),
        .cons_write_strobe (cons_write_strobe),
        .cons_read_strobe  (cons_read_strobe),
        .cons_in_port      (cons_in_port),
        .cons_interrupt    (cons_interrupt),
        .cons_interrupt_ack(cons_interrupt_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       pwe;
        logic [7:0] pid;
        logic [7:0] pdata;
        logic       cwe;
        logic       cre;
        logic [7:0] cid;
        logic [7:0] cdata;
        logic       ack;
        logic [7:0] chk_port;
        logic [7:0] exp_data;
        logic       exp_irq;
    } vec_t;

    vec_t vecs [22];

    // Drive one cycle of stimulus, then idle the strobes and point the consumer at chk_port.
    task automatic do_cycle(input logic pwe, input logic [7:0] pid, input logic [7:0] pdata,
                            input logic cwe, input logic cre, input logic [7:0] cid,
                            input logic [7:0] cdata, input logic ack, input logic [7:0] chk_port);
        @(negedge clk);
        prod_write_strobe  = pwe;
        prod_port_id       = pid;
        prod_out_port      = pdata;
        cons_write_strobe  = cwe;
        cons_read_strobe   = cre;
        cons_port_id       = cid;
        cons_out_port      = cdata;
        cons_interrupt_ack = ack;
        @(posedge clk);
        #1;
        prod_write_strobe  = 1'b0;
        cons_write_strobe  = 1'b0;
        cons_read_strobe   = 1'b0;
        cons_interrupt_ack = 1'b0;
        cons_port_id       = chk_port;
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] exp_data, input logic exp_irq);
        n_checks++;
        if (cons_in_port !== exp_data) begin
            n_fail++;
            $display("FAIL %s: port %02h read %02h, expected %02h", name, cons_port_id,
                     cons_in_port, exp_data);
        end
        n_checks++;
        if (cons_interrupt !== exp_irq) begin
            n_fail++;
            $display("FAIL %s irq: got %0b, expected %0b", name, cons_interrupt, exp_irq);
        end
    endtask

    task automatic peek(input string name, input logic [7:0] port, input logic [7:0] exp_data,
                        input logic exp_irq);
        cons_port_id = port;
        #1;
        check(name, exp_data, exp_irq);
    endtask

    task automatic push(input logic [7:0] key, input logic ack, input logic [7:0] chk_port);
        do_cycle(1'b1, K, key, 1'b0, 1'b0, 8'h00, 8'h00, ack, chk_port);
    endtask

    task automatic pop(input logic [7:0] pt, input logic [7:0] chk_port);
        do_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, D, pt, 1'b0, chk_port);
    endtask

    task automatic idle(input logic ack, input logic [7:0] chk_port);
        do_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, ack, chk_port);
    endtask

    initial begin
        logic [7:0] lvl_exp;
`ifdef KEY_MAILBOX_LEVEL_PORT_EN
        lvl_exp = 8'h03;
`else
        lvl_exp = 8'h00;
`endif
        //            pwe pid   pdata  cwe cre cid cdata  ack chk exp    irq
        vecs[0]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h02, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, D, 8'h00, 1'b0};
        vecs[2]  = '{1'b1, K,     8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, D,     8'h3C, 1'b0, D, 8'h99, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h03, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, D,     8'h00, 1'b0, S, 8'h02, 1'b0};
        vecs[6]  = '{1'b1, K,     8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, K,     8'h02, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, K,     8'h03, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00, 1'b0};
        vecs[9]  = '{1'b1, K,     8'h04, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, S, 8'h00, 1'b0};
        vecs[11] = '{1'b1, K,     8'h05, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, D,     8'h00, 1'b0, D, 8'h01, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, D,     8'h00, 1'b0, D, 8'h02, 1'b0};
        vecs[14] = '{1'b1, K,     8'h06, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h01, 1'b1};
        vecs[15] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, S, 8'h01, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, D,     8'h00, 1'b0, D, 8'h03, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, D,     8'hF0, 1'b0, D, 8'hF4, 1'b0};
        vecs[18] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, D,     8'h00, 1'b0, D, 8'h05, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 8'h00, 1'b1, 1'b0, D,     8'h00, 1'b0, D, 8'h06, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, D,     8'h00, 1'b0, S, 8'h02, 1'b0};
        vecs[21] = '{1'b1, 8'h02, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, S, 8'h02, 1'b0};

        reset = 1'b1;
        prod_write_strobe = 1'b0; prod_port_id = 8'h00; prod_out_port = 8'h00;
        cons_write_strobe = 1'b0; cons_read_strobe = 1'b0;
        cons_port_id = 8'h00; cons_out_port = 8'h00; cons_interrupt_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        foreach (vecs[i]) begin
            do_cycle(vecs[i].pwe, vecs[i].pid, vecs[i].pdata, vecs[i].cwe, vecs[i].cre,
                     vecs[i].cid, vecs[i].cdata, vecs[i].ack, vecs[i].chk_port);
            check($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_irq);
        end

        // Fill to 16 with ack on the crossing push (ack wins), then overflow.
        for (int i = 1; i <= 16; i++) push(8'(i), i == 4, S);
        check("fill16_status", 8'h04, 1'b0);
        push(8'h11, 1'b0, S);
        check("push17_overflow", 8'h0C, 1'b0);
        // Drop while full together with an overflow clear: the set wins.
        do_cycle(1'b1, K, 8'h99, 1'b1, 1'b0, S, 8'h08, 1'b0, S);
        check("ovf_set_beats_clear", 8'h0C, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            pop(8'h00, D);
            check($sformatf("drain%0d", i), 8'(i), 1'b0);
        end
        peek("drained_status", S, 8'h0B, 1'b0);
        do_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, S, 8'h08, 1'b0, S);
        check("ovf_clear", 8'h03, 1'b0);

        // Refill; interrupt rises on the 4th push and stays up without ack.
        for (int i = 0; i < 16; i++) begin
            push(8'h20 + 8'(i), 1'b0, S);
            check($sformatf("refill%0d", i), (i == 15) ? 8'h05 : 8'h01, i >= 3);
        end
        do_cycle(1'b1, K, 8'h40, 1'b1, 1'b0, D, 8'h00, 1'b0, D);
        check("full_push_pop_result", 8'h20, 1'b1);
        peek("full_push_pop_status", S, 8'h05, 1'b1);
        idle(1'b1, S);
        check("ack_full", 8'h05, 1'b0);
        for (int i = 0; i < 16; i++) begin
            pop(8'h00, D);
            check($sformatf("drain2_%0d", i), (i == 15) ? 8'h40 : 8'h21 + 8'(i), 1'b0);
        end

        // Underflow: result must not change.
        do_cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, D, 8'h00, 1'b0, S);
        check("res_valid_cleared", 8'h02, 1'b0);
        pop(8'h55, S);
        check("underflow_status", 8'h12, 1'b0);
        peek("underflow_result", D, 8'h40, 1'b0);
        do_cycle(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, S, 8'h10, 1'b0, S);
        check("underflow_clear", 8'h02, 1'b0);
        // A push in the same cycle does not satisfy a pop on an empty FIFO.
        do_cycle(1'b1, K, 8'h61, 1'b1, 1'b0, D, 8'h00, 1'b0, S);
        check("push_with_empty_pop", 8'h10, 1'b0);
        peek("push_with_empty_pop_res", D, 8'h40, 1'b0);

        peek("level_one_or_zero", L, 8'h00 | ((lvl_exp != 0) ? 8'h01 : 8'h00), 1'b0);
        push(8'h62, 1'b0, L);
        push(8'h63, 1'b0, L);
        check("level_port", lvl_exp, 1'b0);

        // Reset mid-operation with a push in the reset cycle.
        @(negedge clk);
        reset = 1'b1;
        prod_write_strobe = 1'b1; prod_port_id = K; prod_out_port = 8'h77;
        @(posedge clk);
        #1;
        reset = 1'b0;
        prod_write_strobe = 1'b0;
        peek("reset_status", S, 8'h02, 1'b0);
        peek("reset_result", D, 8'h00, 1'b0);
        peek("reset_level", L, 8'h00, 1'b0);
        idle(1'b0, S);
        check("post_reset_idle", 8'h02, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
